// File: rtl/bus_pkg.sv
// Shared bus definitions: default packet width, packet type, default bus geometry
// and the occupancy-counter width helper used by the driver FIFOs.
package bus_pkg;

    localparam int DFLT_PCKG    = 32;
    localparam int DFLT_DEPTH   = 16;
    localparam int DFLT_BITS    = DFLT_PCKG;
    localparam int DFLT_DRIVERS = 4;

    typedef logic [DFLT_PCKG-1:0] pkt_t;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/drvr_fifo_mem.sv
// DEPTH x PCKG storage array for the driver FIFO; no reset on the data.
// Latency: write lands at the clock edge, read is combinational from raddr.
// Backpressure: none, the caller decides when we is asserted.
module drvr_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int PCKG  = 32,
    parameter int AW    = 4
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [PCKG-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [PCKG-1:0] rdata
);

    logic [PCKG-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/drvr_fifo.sv
// Per-driver FWFT transmit FIFO feeding the bus arbiter (DRVR_FIFO_OVWR_OLDEST_EN: overwrite oldest when full).
// Latency: a push is visible on D_pop/pndng one cycle later; pop advances the head at the edge.
// Backpressure: full is advisory; a push while full is dropped (or overwrites) and flags overflow.
module drvr_fifo
    import bus_pkg::*;
#(
    parameter int DEPTH = DFLT_DEPTH,
    parameter int PCKG  = DFLT_PCKG
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [PCKG-1:0]           D_push,
    input  logic                      pop,
    output logic [PCKG-1:0]           D_pop,
    output logic                      pndng,
    output logic                      full,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      clr_flags
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = cnt_w(DEPTH);

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [PCKG-1:0] rdata;
    logic            do_push;
    logic            do_pop;
    logic            ovf_evt;
    logic            udf_evt;
    logic            ovwr;
    logic            wr_en;
    logic            rd_adv;
    logic [CW-1:0]   count_nxt;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        do_pop  = pop & pndng;
        ovf_evt = push & full & ~pop;
        udf_evt = pop & ~pndng;
        do_push = push & (~full | do_pop);
`ifdef DRVR_FIFO_OVWR_OLDEST_EN
        ovwr    = ovf_evt;
`else
        ovwr    = 1'b0;
`endif
        wr_en   = do_push | ovwr;
        rd_adv  = do_pop | ovwr;

        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CW'(1);
        end else if (do_pop && !do_push) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pndng     <= 1'b0;
            full      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_adv) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count_nxt;
            pndng <= (count_nxt != '0);
            full  <= (count_nxt == CW'(DEPTH));
            // A new event in the same cycle as clr_flags keeps the flag set.
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end
            if (udf_evt) begin
                underflow <= 1'b1;
            end else if (clr_flags) begin
                underflow <= 1'b0;
            end
        end
    end

    drvr_fifo_mem #(
        .DEPTH (DEPTH),
        .PCKG  (PCKG),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (D_push),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign D_pop = pndng ? rdata : '0;

endmodule

// File: tb/tb_drvr_fifo.sv
// Directed bench for drvr_fifo at DEPTH=16, PCKG=32 with a reference queue for
// the interleaved section.
module tb_drvr_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        push;
    logic [31:0] D_push;
    logic        pop;
    logic [31:0] D_pop;
    logic        pndng;
    logic        full;
    logic [4:0]  count;
    logic        overflow;
    logic        underflow;
    logic        clr_flags;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] q[$];
    logic [31:0] exp_v;

    always #5 clk = ~clk;

    drvr_fifo #(.DEPTH(16), .PCKG(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .D_push    (D_push),
        .pop       (pop),
        .D_pop     (D_pop),
        .pndng     (pndng),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow),
        .clr_flags (clr_flags)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push      = 1'b0;
        pop       = 1'b0;
        clr_flags = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        push      = 1'b1;
        D_push    = 32'hDEAD_BEEF;
        pop       = 1'b0;
        clr_flags = 1'b0;

        // 1: reset held with push active
        repeat (3) tick();
        chk("rst_pndng", pndng, 0);
        chk("rst_count", count, 0);
        chk("rst_dpop", D_pop, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);
        idle();
        reset = 1'b1;
        tick();
        chk("rel_pndng", pndng, 0);

        // 2: basic ordering
        push = 1'b1;
        for (int i = 0; i < 3; i++) begin
            D_push = 32'h17 + i;
            tick();
        end
        idle();
        chk("ord_count", count, 3);
        chk("ord_pndng", pndng, 1);
        pop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("ord_dpop", D_pop, 32'h17 + i);
            chk("ord_cnt_dn", count, 3 - i);
            tick();
        end
        idle();
        chk("ord_pndng_fall", pndng, 0);
        chk("ord_count0", count, 0);

        // 3: fill and overflow
        push = 1'b1;
        for (int i = 0; i < 17; i++) begin
            D_push = i;
            tick();
            if (i == 15) begin
                chk("fill_full", full, 1);
                chk("fill_ovf_clr", overflow, 0);
            end
        end
        idle();
        chk("fill_ovf", overflow, 1);
        chk("fill_count", count, 16);
        pop = 1'b1;
        for (int i = 0; i < 16; i++) begin
`ifdef DRVR_FIFO_OVWR_OLDEST_EN
            exp_v = i + 1;
`else
            exp_v = i;
`endif
            chk("fill_dpop", D_pop, exp_v);
            tick();
        end
        idle();
        chk("fill_empty", pndng, 0);
        clr_flags = 1'b1;
        tick();
        idle();
        chk("fill_ovf_cleared", overflow, 0);

        // 4: push+pop while full
        push = 1'b1;
        for (int i = 0; i < 16; i++) begin
            D_push = 32'h20 + i;
            tick();
        end
        chk("fp_full", full, 1);
        D_push = 32'hAA;
        pop    = 1'b1;
        tick();
        idle();
        chk("fp_count", count, 16);
        chk("fp_ovf", overflow, 0);
        chk("fp_full2", full, 1);
        pop = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_v = (i == 15) ? 32'hAA : 32'h21 + i;
            chk("fp_dpop", D_pop, exp_v);
            tick();
        end
        idle();
        chk("fp_empty", count, 0);

        // 5: push+pop while empty, then flag clear and set-wins
        push   = 1'b1;
        pop    = 1'b1;
        D_push = 32'h55;
        tick();
        idle();
        chk("ep_udf", underflow, 1);
        chk("ep_count", count, 1);
        chk("ep_dpop", D_pop, 32'h55);
        clr_flags = 1'b1;
        tick();
        chk("ep_udf_clr", underflow, 0);
        chk("ep_count_hold", count, 1);
        pop = 1'b1;
        tick();
        chk("ep_drained", count, 0);
        tick();
        chk("ep_set_wins", underflow, 1);
        pop = 1'b0;
        tick();
        idle();
        chk("ep_udf_clr2", underflow, 0);

        // 6: interleaved traffic against reference queue
        for (int i = 0; i < 40; i++) begin
            chk("wr_count", count, 32'(q.size()));
            if (q.size() > 0) begin
                chk("wr_dpop", D_pop, q[0]);
            end
            push   = (i % 4) != 3;
            pop    = (i % 2) == 1;
            D_push = 32'h100 + i;
            tick();
            if (pop && q.size() > 0) begin
                void'(q.pop_front());
            end
            if (push) begin
                q.push_back(D_push);
            end
        end
        idle();
        for (int i = 0; i < 16 && q.size() > 5; i++) begin
            pop = 1'b1;
            tick();
            void'(q.pop_front());
        end
        idle();
        chk("ar_count5", count, 5);
        chk("ar_dpop", D_pop, q[0]);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_pndng", pndng, 0);
        chk("ar_count", count, 0);
        chk("ar_dpop0", D_pop, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("ar_rel_pndng", pndng, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
